// File: rtl/full_adder_if.sv
// full_adder_if: operand/result bundle for the registered ripple-carry adder
interface full_adder_if #(parameter int WIDTH = 1);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             out_valid;
  modport master (output in_valid, a, b, c, input s, co, out_valid);
  modport slave  (input in_valid, a, b, c, output s, co, out_valid);
endinterface

// File: rtl/full_adder.sv
// full_adder: registered ripple-carry adder, {co,s} = a + b + c with one-cycle latency
module full_adder #(parameter int WIDTH = 1) (
  input logic        clk,
  input logic        rst,
  full_adder_if.slave bus
);
  logic [WIDTH-1:0] s_q, s_d, sum;
  logic             co_q, co_d;
  logic             vld_q, vld_d;
  logic [WIDTH:0]   carry;
  // ripple chain of full-adder cells; results are captured only on valid input
  always_comb begin
    carry[0] = bus.c;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = bus.a[i] ^ bus.b[i] ^ carry[i];
      carry[i+1] = (bus.a[i] & bus.b[i]) | (carry[i] & (bus.a[i] ^ bus.b[i]));
    end
    s_d = bus.in_valid ? sum : s_q;
    co_d = bus.in_valid ? carry[WIDTH] : co_q;
    vld_d = bus.in_valid;
  end
  // output registers; reset clears results and drops any pending valid
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      co_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      s_q <= s_d;
      co_q <= co_d;
      vld_q <= vld_d;
    end
  end
  assign bus.s = s_q;
  assign bus.co = co_q;
  assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed and random checks of the registered adder at WIDTH 1, 4 and 8
module tb_full_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  full_adder_if #(.WIDTH(1)) i1 ();
  full_adder_if #(.WIDTH(4)) i4 ();
  full_adder_if #(.WIDTH(8)) i8 ();
  full_adder #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
  full_adder #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(i4));
  full_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(i8));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [2:0] vec [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b101, 3'b111};
  logic [1:0] res [8] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b11};
  logic [7:0] ra, rb;
  logic       rc;
  int         rbad;

  initial begin
    i1.in_valid = 0; i1.a = 0; i1.b = 0; i1.c = 0;
    i4.in_valid = 0; i4.a = 0; i4.b = 0; i4.c = 0;
    i8.in_valid = 0; i8.a = 0; i8.b = 0; i8.c = 0;
    rst = 1;
    tick;
    tick;
    chk("rst_s1", 64'(i1.s), 0);
    chk("rst_co1", 64'(i1.co), 0);
    chk("rst_v1", 64'(i1.out_valid), 0);
    chk("rst_w4", 64'({i4.co, i4.s, i4.out_valid}), 0);
    chk("rst_w8", 64'({i8.co, i8.s, i8.out_valid}), 0);
    rst = 0;
    for (int k = 0; k < 8; k++) begin
      i1.a = vec[k][2]; i1.b = vec[k][1]; i1.c = vec[k][0]; i1.in_valid = 1;
      tick;
      chk($sformatf("tt_s_%03b", vec[k]), 64'(i1.s), 64'(res[k][1]));
      chk($sformatf("tt_co_%03b", vec[k]), 64'(i1.co), 64'(res[k][0]));
      chk($sformatf("tt_v_%03b", vec[k]), 64'(i1.out_valid), 1);
    end
    i1.a = 1; i1.b = 1; i1.c = 1; i1.in_valid = 1;
    tick;
    i1.a = 0; i1.in_valid = 0;
    tick;
    chk("hold_s", 64'(i1.s), 1);
    chk("hold_co", 64'(i1.co), 1);
    chk("hold_v", 64'(i1.out_valid), 0);
    i1.a = 'x; i1.b = 'z; i1.c = 'x;
    tick;
    chk("xin_s", 64'(i1.s), 1);
    chk("xin_co", 64'(i1.co), 1);
    chk("xin_v", 64'(i1.out_valid), 0);
    i1.a = 0; i1.b = 0; i1.c = 0;
    i4.a = 4'hF; i4.b = 4'h1; i4.c = 0; i4.in_valid = 1;
    tick;
    chk("w4_f_1", 64'({i4.co, i4.s}), 64'h10);
    chk("w4_f_1_v", 64'(i4.out_valid), 1);
    i4.a = 4'h7; i4.b = 4'h8; i4.c = 1;
    tick;
    chk("w4_7_8_c", 64'({i4.co, i4.s}), 64'h10);
    i4.a = 4'h5; i4.b = 4'h3; i4.c = 0;
    tick;
    chk("w4_5_3", 64'({i4.co, i4.s}), 64'h08);
    i4.a = 4'hA; i4.b = 4'h6; i4.c = 0; i4.in_valid = 1; rst = 1;
    tick;
    rst = 0; i4.in_valid = 0;
    chk("rstwin_s", 64'(i4.s), 0);
    chk("rstwin_co", 64'(i4.co), 0);
    chk("rstwin_v", 64'(i4.out_valid), 0);
    rbad = 0;
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      i8.a = ra; i8.b = rb; i8.c = rc; i8.in_valid = 1;
      tick;
      chk("w8_rand", 64'({i8.co, i8.s}), 64'(9'(ra) + 9'(rb) + 9'(rc)));
      chk("w8_rand_v", 64'(i8.out_valid), 1);
    end
    i8.in_valid = 0;
    tick;
    chk("w8_drop_v", 64'(i8.out_valid), 0);
    chk("w8_drop_hold", 64'({i8.co, i8.s}), 64'(9'(ra) + 9'(rb) + 9'(rc)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered binary adder built from a ripple chain of 1-bit full-adder cells: computes a + b + c and registers sum and carry-out.
- Default WIDTH=1 gives the classic single-bit full adder (sum/carry truth table).
- Wider WIDTH forms a multi-bit ripple-carry adder, e.g. WIDTH=4 for the 4-bit adder datapath.
- Sits in the arithmetic datapath as a leaf block with one-cycle latency.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, operands valid this cycle.
- a, input, WIDTH, addend A (unsigned).
- b, input, WIDTH, addend B (unsigned).
- c, input, 1, carry-in.
- s, output, WIDTH, registered sum.
- co, output, 1, registered carry-out.
- out_valid, output, 1, s/co hold a result computed from a valid input.

Behaviour:
- The interface has one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset:
  - If rst=1 at a rising clk edge, then s=0, co=0 and out_valid=0 after that edge.
  - rst has priority over in_valid.
  - Reset mid-operation discards any pending result.
- Datapath is a ripple chain of WIDTH full-adder cells:
  - sum_i = a_i XOR b_i XOR carry_i
  - carry_(i+1) = (a_i AND b_i) OR (carry_i AND (a_i XOR b_i))
  - carry_0 = c; co = carry_WIDTH.
- Arithmetic: {co, s} = a + b + c, computed exactly with WIDTH+1 result bits. No overflow is lost; carry-out absorbs wrap-around.
- Latency is 1 cycle. If in_valid=1 and rst=0 at edge N, then after edge N:
  - s and co reflect the operands sampled at edge N;
  - out_valid=1.
- If in_valid=0 and rst=0 at an edge:
  - s and co hold their previous values;
  - out_valid=0 after that edge.
- Throughput is one result per cycle. Back-to-back valid inputs each produce a result on the following cycle. There is no backpressure.
- Single-bit truth table (a b c -> s co):
  - 000->0 0, 001->1 0, 010->1 0, 100->1 0
  - 011->0 1, 110->0 1, 101->0 1, 111->1 1
- X/Z on inputs while in_valid=0 must not disturb s or co.

Test Plan:
- WIDTH=1, rst held 2 cycles -> s=0, co=0, out_valid=0.
- WIDTH=1, release rst, apply all 8 combinations of (a,b,c) with in_valid=1, one per cycle (order 000,001,010,100,011,110,101,111) -> next cycle s/co = 0/0, 1/0, 1/0, 1/0, 0/1, 0/1, 0/1, 1/1, with out_valid=1 each cycle.
- WIDTH=1, a=1, b=1, c=1, in_valid=1 for one cycle then in_valid=0 with a=0 -> s=1, co=1 hold; out_valid drops to 0.
- WIDTH=4:
  - a=4'hF, b=4'h1, c=0 -> s=4'h0, co=1
  - a=4'h7, b=4'h8, c=1 -> s=4'h0, co=1
  - a=4'h5, b=4'h3, c=0 -> s=4'h8, co=0
- WIDTH=4, assert rst in the same cycle as in_valid=1 with a=4'hA, b=4'h6 -> s=0, co=0, out_valid=0 (reset wins).
- WIDTH=8, random a/b/c for 1000 cycles -> {co,s} equals a+b+c from the previous cycle.
